// File: rtl/mem_access_unit.sv
// mem_access_unit
// ----------------
// PC / instruction-register / memory-port sequencer. One memory port is shared
// between instruction fetch and data load/store. Data requests win over fetch
// when both arrive together. Variable-latency memory is supported through the
// mem_ready handshake. The control FSM outside only raises requests. This block
// owns PC, IR and the load-data register.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after MAX_WAIT
// cycles without mem_ready (err pulses). In the default build the unit waits
// indefinitely and err is tied low.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   fetch_req             fetch instruction at PC (level, sampled in IDLE)
//   data_req, data_we     data access request, 1 = store / 0 = load
//   data_addr, wdata      data address (low ADDR_W bits used), store data
//   pc_load, pc_target    load a branch/jump target into PC
//   mem_rdata, mem_ready  memory read data, command-complete strobe
//   mem_cmd               00 none, 01 read, 10 write (registered)
//   mem_addr, mem_wdata   registered memory address / store data
//   pc, ir, rdata         program counter, instruction register, last load data
//   busy                  access in flight (any state but IDLE)
//   done, err             1-cycle completion / timeout-abort pulses
module mem_access_unit #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [DATA_W-1:0] data_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRD   = 2'd2,
    S_DWR   = 2'd3
  } state_e;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          mem_cmd_q, mem_cmd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0]   data_addr_lo;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
`else
  logic [31:0] unused_max_wait;
  assign unused_max_wait = MAX_WAIT;
`endif

  assign data_addr_lo = data_addr[ADDR_W-1:0];

  generate
    if (DATA_W > ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^data_addr[DATA_W-1:ADDR_W];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    rdata_d     = rdata_q;
    mem_cmd_d   = mem_cmd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    if (state_q == S_IDLE) begin
      if (pc_load) begin
        pc_d = pc_target;
      end
      if (data_req) begin
        state_d    = data_we ? S_DWR : S_DRD;
        mem_addr_d = data_addr_lo;
        mem_cmd_d  = data_we ? CMD_WRITE : CMD_READ;
        if (data_we) begin
          mem_wdata_d = wdata;
        end
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end else if (fetch_req && !pc_load) begin
        // A same-cycle pc_load defers the fetch by one cycle so it uses the new PC.
        state_d    = S_FETCH;
        mem_addr_d = pc_q;
        mem_cmd_d  = CMD_READ;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
    end else begin
      // Latest pc_load during an access wins; it is applied when the access ends.
      if (pc_load) begin
        pend_vld_d = 1'b1;
        pend_pc_d  = pc_target;
      end

      if (mem_ready) begin
        state_d    = S_IDLE;
        mem_cmd_d  = CMD_NONE;
        done_d     = 1'b1;
        pend_vld_d = 1'b0;
        if (state_q == S_FETCH) begin
          ir_d = mem_rdata;
          pc_d = pc_q + ADDR_W'(1);
        end
        if (state_q == S_DRD) begin
          rdata_d = mem_rdata;
        end
        // A pending jump target overrides the sequential increment.
        if (pc_load) begin
          pc_d = pc_target;
        end else if (pend_vld_q) begin
          pc_d = pend_pc_q;
        end
      end
`ifdef MEM_TIMEOUT_EN
      else if (wait_cnt_q == WAIT_LAST) begin
        state_d    = S_IDLE;
        mem_cmd_d  = CMD_NONE;
        err_d      = 1'b1;
        pend_vld_d = 1'b0;
        if (pc_load) begin
          pc_d = pc_target;
        end else if (pend_vld_q) begin
          pc_d = pend_pc_q;
        end
      end else begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      rdata_q     <= '0;
      mem_cmd_q   <= CMD_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_pc_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      rdata_q     <= rdata_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pend_vld_q  <= pend_vld_d;
      pend_pc_q   <= pend_pc_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (ADDR_W=9, DATA_W=16).
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] wdata;
  logic        pc_load;
  logic [8:0]  pc_target;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  pc;
  logic [15:0] ir;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(
    .ADDR_W  (9),
    .DATA_W  (16),
    .RESET_PC(9'h000),
    .MAX_WAIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_req(fetch_req),
    .data_req (data_req),
    .data_we  (data_we),
    .data_addr(data_addr),
    .wdata    (wdata),
    .pc_load  (pc_load),
    .pc_target(pc_target),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .pc       (pc),
    .ir       (ir),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; wdata = '0; pc_load = 1'b0; pc_target = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    step(); step();

    check_val("rst_pc",    pc,      32'h0);
    check_val("rst_ir",    ir,      32'h0);
    check_val("rst_rdata", rdata,   32'h0);
    check_val("rst_cmd",   mem_cmd, 32'h0);
    check_val("rst_addr",  mem_addr,32'h0);
    check_val("rst_busy",  busy,    32'h0);
    check_val("rst_done",  done,    32'h0);
    check_val("rst_err",   err,     32'h0);
    reset = 1'b0;
    step();

    // Minimum-latency fetch from pc=0
    fetch_req = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hA5C3;
    step();
    check_val("f1_cmd",  mem_cmd,  32'h1);
    check_val("f1_addr", mem_addr, 32'h0);
    check_val("f1_busy", busy,     32'h1);
    fetch_req = 1'b0;
    step();
    check_val("f1_done", done,    32'h1);
    check_val("f1_ir",   ir,      32'hA5C3);
    check_val("f1_pc",   pc,      32'h1);
    check_val("f1_idle", mem_cmd, 32'h0);
    mem_ready = 1'b0;
    step();
    check_val("f1_done_pulse", done, 32'h0);

    // Simultaneous data store and fetch: store first
    fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b1;
    data_addr = 16'h0040; wdata = 16'h1234;
    step();
    check_val("w_cmd",   mem_cmd,   32'h2);
    check_val("w_addr",  mem_addr,  32'h040);
    check_val("w_wdata", mem_wdata, 32'h1234);
    data_req = 1'b0; data_we = 1'b0; mem_ready = 1'b1;
    step();
    check_val("w_done", done,    32'h1);
    check_val("w_idle", mem_cmd, 32'h0);
    check_val("w_pc",   pc,      32'h1);
    step();
    check_val("wf_cmd",  mem_cmd, 32'h1);
    check_val("wf_addr", mem_addr,32'h1);
    check_val("wf_done", done,    32'h0);
    fetch_req = 1'b0; mem_rdata = 16'h7777;
    step();
    check_val("wf_ir", ir, 32'h7777);
    check_val("wf_pc", pc, 32'h2);
    mem_ready = 1'b0;
    step();

    // Load with three wait cycles; upper data_addr bits ignored
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'hFE23;
    step();
    data_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("r_cmd_hold",  mem_cmd,  32'h1);
      check_val("r_addr_hold", mem_addr, 32'h023);
      check_val("r_no_done",   done,     32'h0);
      if (i == 3) begin
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
      end
      step();
    end
    check_val("r_done",  done,  32'h1);
    check_val("r_rdata", rdata, 32'hBEEF);
    check_val("r_ir",    ir,    32'h7777);
    check_val("r_pc",    pc,    32'h2);
    mem_ready = 1'b0;
    step();
    check_val("r_single_done", done, 32'h0);

    // PC wrap at 9'h1FF
    pc_load = 1'b1; pc_target = 9'h1FF;
    step();
    pc_load = 1'b0;
    check_val("j_pc", pc, 32'h1FF);
    fetch_req = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1111;
    step();
    check_val("wrap_addr", mem_addr, 32'h1FF);
    fetch_req = 1'b0;
    step();
    check_val("wrap_pc", pc, 32'h0);
    check_val("wrap_ir", ir, 32'h1111);
    mem_ready = 1'b0;
    step();

    // pc_load beats a same-cycle fetch; the fetch follows with the new PC
    pc_load = 1'b1; pc_target = 9'h0AA; fetch_req = 1'b1;
    step();
    pc_load = 1'b0;
    check_val("pl_pc",   pc,      32'h0AA);
    check_val("pl_busy", busy,    32'h0);
    check_val("pl_cmd",  mem_cmd, 32'h0);
    step();
    check_val("pl_fcmd",  mem_cmd,  32'h1);
    check_val("pl_faddr", mem_addr, 32'h0AA);
    fetch_req = 1'b0;

    // pc_load mid-fetch: latest pending target wins over the increment
    pc_load = 1'b1; pc_target = 9'h100;
    step();
    pc_target = 9'h055;
    step();
    pc_load = 1'b0;
    check_val("pend_pc_hold", pc, 32'h0AA);
    mem_ready = 1'b1; mem_rdata = 16'h2222;
    step();
    check_val("pend_done", done, 32'h1);
    check_val("pend_pc",   pc,   32'h055);
    check_val("pend_ir",   ir,   32'h2222);
    mem_ready = 1'b0;
    step();

`ifdef MEM_TIMEOUT_EN
    // Timeout abort after MAX_WAIT=4 cycles without mem_ready
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("to_wait_err", err, 32'h0);
      check_val("to_wait_cmd", mem_cmd, 32'h1);
    end
    step();
    check_val("to_err",  err,     32'h1);
    check_val("to_done", done,    32'h0);
    check_val("to_cmd",  mem_cmd, 32'h0);
    check_val("to_pc",   pc,      32'h055);
    check_val("to_ir",   ir,      32'h2222);
    step();
    check_val("to_err_pulse", err, 32'h0);
`endif

    // Reset in the middle of a fetch
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check_val("mr_cmd_before", mem_cmd, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_val("mr_cmd",  mem_cmd, 32'h0);
    check_val("mr_pc",   pc,      32'h0);
    check_val("mr_busy", busy,    32'h0);
    check_val("mr_ir",   ir,      32'h0);
    mem_ready = 1'b1;
    step();
    check_val("mr_no_done", done, 32'h0);
    reset = 1'b0;
    step();
    check_val("mr_no_done2", done, 32'h0);
    check_val("mr_idle",     mem_cmd, 32'h0);
    check_val("mr_err",      err,  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
